conware_frame_engine: RTL and testbench

//  Multi-generation Game of Life engine for a full 2D frame.
//  - Accepts a frame of colour pixels on an AXI-Stream slave and converts each pixel to one alive/dead bit.
//  - Runs a run-time-selected number of generations on an internal WIDTH x HEIGHT bit grid.
//  - Streams the result out on an AXI-Stream master as colour pixels.
//  - Replaces the single-row, single-generation, combinational-core pipeline.

---
 rtl/conware_frame_engine.sv | 216 +++++++++++++++++++++
 tb/tb_conware_frame_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_frame_engine.sv
// Multi-generation Game of Life engine: AXI-Stream frame in, N generations on a bit grid, frame out.
// Define CONWARE_TORUS_EN for toroidal (wrap-around) edges; otherwise off-grid cells are dead.
module conware_frame_engine #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] dead_color,
  input  logic [GEN_W-1:0]  generations,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PREV_IDX = IDX_W'(N - 2);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

`ifdef CONWARE_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [ROW_W-1:0]   row;
  logic [GEN_W-1:0]   gen_cnt;
  logic [N-1:0]       cur;
  logic [N-1:0]       nxt;
  logic               s_tready_q;
  logic               m_tvalid_q;
  logic               m_tlast_q;
  logic               frame_err_q;

  logic               pix_alive;
  logic               s_hs;
  logic               m_hs;
  logic [GEN_W-1:0]   gens_eff;
  logic [N-1:0]       load_grid;
  logic [ROW_W-1:0]   row_up_idx;
  logic [ROW_W-1:0]   row_dn_idx;
  logic [WIDTH-1:0]   row_up;
  logic [WIDTH-1:0]   row_mid;
  logic [WIDTH-1:0]   row_dn;
  logic [WIDTH+1:0]   ext_up;
  logic [WIDTH+1:0]   ext_mid;
  logic [WIDTH+1:0]   ext_dn;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   new_row;
  logic [N-1:0]       nxt_c;

  assign pix_alive = (S_AXIS_TDATA == alive_color);
  assign s_hs      = (state == ST_LOAD) && s_tready_q && S_AXIS_TVALID;
  assign m_hs      = m_tvalid_q && M_AXIS_TREADY;
  // generations is latched on beat 0, so a frame ending on beat 0 must use the port directly
  assign gens_eff  = (idx == '0) ? generations : gen_cnt;

  assign S_AXIS_TREADY = s_tready_q;
  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDATA  = m_tvalid_q ? (cur[idx] ? alive_color : dead_color) : '0;
  assign busy          = (state != ST_LOAD);
  assign frame_err     = frame_err_q;

  // Grid after the current input beat; an early TLAST clears every later cell
  always_comb begin
    load_grid = cur;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == idx) begin
        load_grid[i] = pix_alive;
      end else if (S_AXIS_TLAST && (IDX_W'(i) > idx)) begin
        load_grid[i] = 1'b0;
      end
    end
  end

  // Fetch rows r-1, r, r+1 of the current generation
  always_comb begin
    row_up_idx = (row == '0) ? LAST_ROW : row - ROW_W'(1);
    row_dn_idx = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
    row_up  = '0;
    row_mid = '0;
    row_dn  = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (ROW_W'(r) == row)        row_mid = cur[r*WIDTH +: WIDTH];
      if (ROW_W'(r) == row_up_idx) row_up  = cur[r*WIDTH +: WIDTH];
      if (ROW_W'(r) == row_dn_idx) row_dn  = cur[r*WIDTH +: WIDTH];
    end
    if (!TORUS && (row == '0))      row_up = '0;
    if (!TORUS && (row == LAST_ROW)) row_dn = '0;
  end

  // Bit 0 of each extended row is column -1, bit WIDTH+1 is column WIDTH
  always_comb begin
    if (TORUS) begin
      ext_up  = {row_up[0],  row_up,  row_up[WIDTH-1]};
      ext_mid = {row_mid[0], row_mid, row_mid[WIDTH-1]};
      ext_dn  = {row_dn[0],  row_dn,  row_dn[WIDTH-1]};
    end else begin
      ext_up  = {1'b0, row_up,  1'b0};
      ext_mid = {1'b0, row_mid, 1'b0};
      ext_dn  = {1'b0, row_dn,  1'b0};
    end
  end

  // B3/S23 for one row
  always_comb begin
    cnt     = '0;
    new_row = '0;
    for (int c = 0; c < WIDTH; c++) begin
      cnt = 4'(ext_up[c]) + 4'(ext_up[c+1]) + 4'(ext_up[c+2])
          + 4'(ext_mid[c])                  + 4'(ext_mid[c+2])
          + 4'(ext_dn[c]) + 4'(ext_dn[c+1]) + 4'(ext_dn[c+2]);
      new_row[c] = (cnt == 4'd3) || ((cnt == 4'd2) && ext_mid[c+1]);
    end
  end

  always_comb begin
    nxt_c = nxt;
    for (int r = 0; r < HEIGHT; r++) begin
      if (ROW_W'(r) == row) nxt_c[r*WIDTH +: WIDTH] = new_row;
    end
  end

  // Frame FSM: LOAD -> COMPUTE -> DRAIN -> LOAD, with gens==0 skipping COMPUTE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_LOAD;
      idx         <= '0;
      row         <= '0;
      gen_cnt     <= '0;
      cur         <= '0;
      nxt         <= '0;
      s_tready_q  <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          s_tready_q <= 1'b1;
          if (s_hs) begin
            cur <= load_grid;
            if (idx == '0) gen_cnt <= generations;
            if ((idx == LAST_IDX) || S_AXIS_TLAST) begin
              frame_err_q <= (idx != LAST_IDX) || !S_AXIS_TLAST;
              s_tready_q  <= 1'b0;
              idx         <= '0;
              row         <= '0;
              if (gens_eff == '0) begin
                state      <= ST_DRAIN;
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= 1'b0;
              end else begin
                state <= ST_COMPUTE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          nxt <= nxt_c;
          if (row == LAST_ROW) begin
            cur     <= nxt_c;
            row     <= '0;
            gen_cnt <= gen_cnt - GEN_W'(1);
            if (gen_cnt == GEN_W'(1)) begin
              state      <= ST_DRAIN;
              m_tvalid_q <= 1'b1;
              m_tlast_q  <= 1'b0;
            end
          end else begin
            row <= row + ROW_W'(1);
          end
        end
        ST_DRAIN: begin
          if (m_hs) begin
            if (idx == LAST_IDX) begin
              state      <= ST_LOAD;
              idx        <= '0;
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              s_tready_q <= 1'b1;
            end else begin
              idx       <= idx + IDX_W'(1);
              m_tlast_q <= (idx == PREV_IDX);
            end
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conware_frame_engine.sv
// Directed bench for conware_frame_engine on a 5x5 grid with a frame-level Life reference model.
module tb_conware_frame_engine;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 5;
  localparam int unsigned N  = W * H;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 8;
  localparam logic [DW-1:0] ALIVE = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] DEAD  = 32'h0000_0000;

  typedef logic [N-1:0] grid_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] alive_color;
  logic [DW-1:0] dead_color;
  logic [GW-1:0] generations;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic          frame_err;

  conware_frame_engine #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
    .clk(clk), .rstn(rstn),
    .alive_color(alive_color), .dead_color(dead_color), .generations(generations),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          out_idx = 0;
  int          err_pulses = 0;
  int          ready_mode = 0;
  bit          exp_active = 1'b0;
  grid_t       exp_grid;
  grid_t       got_grid;
  logic [DW-1:0] in_pix [N];
  logic        smp_s_ready, smp_m_valid, smp_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain neighbour counting over the whole frame
  function automatic grid_t life_step(input grid_t g);
    grid_t res = '0;
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
`ifdef CONWARE_TORUS_EN
            rr = (rr + int'(H)) % int'(H);
            cc = (cc + int'(W)) % int'(W);
`else
            if (rr < 0 || rr >= int'(H) || cc < 0 || cc >= int'(W)) continue;
`endif
            n += int'(g[rr*int'(W) + cc]);
          end
        end
        res[r*int'(W) + c] = (n == 3) || (n == 2 && g[r*int'(W) + c]);
      end
    end
    return res;
  endfunction

  function automatic grid_t classify(input int last_beat);
    grid_t g = '0;
    for (int i = 0; i < int'(N); i++) g[i] = (i <= last_beat) && (in_pix[i] == ALIVE);
    return g;
  endfunction

  // One cycle: sample/compare at negedge, drive downstream ready just after posedge
  task automatic tick();
    @(negedge clk);
    smp_s_ready = s_tready;
    smp_m_valid = m_tvalid;
    smp_busy    = busy;
    if (frame_err) err_pulses++;
    if (m_tvalid) begin
      if (!exp_active || out_idx >= int'(N)) begin
        checks++;
        failures++;
        $display("FAIL spurious_beat actual_tdata=%0h required=no_valid", m_tdata);
      end else begin
        check($sformatf("out_beat%0d", out_idx), 64'({m_tlast, busy, m_tdata}),
              64'({(out_idx == int'(N) - 1), 1'b1, (exp_grid[out_idx] ? ALIVE : DEAD)}));
        if (m_tready) begin
          got_grid[out_idx] = (m_tdata == ALIVE);
          out_idx++;
        end
      end
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic start_frame(input int last_beat, input int gens);
    exp_grid = classify(last_beat);
    for (int g = 0; g < gens; g++) exp_grid = life_step(exp_grid);
    out_idx    = 0;
    got_grid   = '0;
    err_pulses = 0;
    exp_active = 1'b1;
  endtask

  task automatic send_beats(input int last_beat, input bit tlast_on, input int gens);
    generations = GW'(gens);
    for (int i = 0; i <= last_beat; i++) begin
      int n = 0;
      s_tdata  = in_pix[i];
      s_tvalid = 1'b1;
      s_tlast  = tlast_on && (i == last_beat);
      tick();
      while (!smp_s_ready && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) check($sformatf("input_accept_timeout%0d", i), 64'(n), 64'd0);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic run_frame(input string name, input int last_beat, input bit tlast_on,
                           input int gens, input int exp_err);
    int n;
    start_frame(last_beat, gens);
    send_beats(last_beat, tlast_on, gens);
    tick();
    check({name, "_busy_after_load"}, 64'({smp_busy, smp_s_ready}), 64'(2'b10));
    n = 0;
    while (!smp_m_valid && n < 5 * gens + 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(5 * gens));
    n = 0;
    while (out_idx < int'(N) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_beat_count"}, 64'(out_idx), 64'(N));
    tick();
    check({name, "_idle"}, 64'({smp_busy, smp_m_valid, smp_s_ready}), 64'(3'b001));
    check({name, "_frame_err_pulses"}, 64'(err_pulses), 64'(exp_err));
    exp_active = 1'b0;
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({s_tready, m_tvalid, m_tlast, busy, frame_err, m_tdata}), 64'd0);
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < int'(N); i++) in_pix[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N); i++) begin
      int r = int'($urandom_range(0, 2));
      in_pix[i] = (r == 0) ? ALIVE : (r == 1) ? DEAD : DW'($urandom);
    end
  endtask

  initial begin
    int n;
    alive_color = ALIVE;
    dead_color  = DEAD;
    generations = '0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    m_tready    = 1'b0;

    repeat (3) @(posedge clk);
    #2 check_reset("reset_values");
    @(negedge clk) rstn = 1'b1;
    #1 check("tready_low_at_release", 64'(s_tready), 64'd0);
    tick();
    check("tready_rises_after_release", 64'(smp_s_ready), 64'd1);

    // Blinker, one and two generations
    fill(DEAD);
    in_pix[11] = ALIVE; in_pix[12] = ALIVE; in_pix[13] = ALIVE;
    run_frame("blinker_g1", 24, 1'b1, 1, 0);
    check("model_blinker_g1", 64'(exp_grid), 64'h0021080);
    check("dut_blinker_g1", 64'(got_grid), 64'h0021080);
    run_frame("blinker_g2", 24, 1'b1, 2, 0);
    check("dut_blinker_g2", 64'(got_grid), 64'h0003800);

    // Passthrough of a random frame
    fill_random();
    run_frame("passthrough", 24, 1'b1, 0, 0);
    check("passthrough_bits", 64'(got_grid), 64'(classify(24)));

    // Random downstream backpressure
    fill_random();
    ready_mode = 1;
    run_frame("backpressure", 24, 1'b1, 3, 0);
    ready_mode = 0;

    // Early TLAST on beat 9, then a missing TLAST on beat 24
    fill(ALIVE);
    run_frame("early_tlast", 9, 1'b1, 0, 1);
    check("early_tlast_bits", 64'(got_grid), 64'h00003FF);
    fill_random();
    run_frame("missing_tlast", 24, 1'b0, 1, 1);

    // Glider, 20 generations
    fill(DEAD);
    in_pix[1] = ALIVE; in_pix[7] = ALIVE; in_pix[10] = ALIVE; in_pix[11] = ALIVE; in_pix[12] = ALIVE;
    run_frame("glider_g20", 24, 1'b1, 20, 0);
`ifdef CONWARE_TORUS_EN
    check("glider_torus_wraps", 64'(got_grid), 64'h0001C82);
`else
    check("glider_bounded_block", 64'(got_grid), 64'h18C0000);
`endif

    // Reset in the middle of COMPUTE
    send_beats(24, 1'b1, 3);
    repeat (6) tick();
    #2 rstn = 1'b0;
    #1 check_reset("reset_mid_compute");
    @(negedge clk) rstn = 1'b1;
    tick();
    check("idle_after_compute_reset", 64'({smp_busy, smp_m_valid, smp_s_ready}), 64'(3'b001));

    // Reset in the middle of DRAIN
    fill(DEAD);
    in_pix[11] = ALIVE; in_pix[12] = ALIVE; in_pix[13] = ALIVE;
    start_frame(24, 1);
    ready_mode = 1;
    send_beats(24, 1'b1, 1);
    n = 0;
    while (out_idx < 10 && n < 3000) begin
      tick();
      n++;
    end
    check("drain_reached_beat10", 64'(out_idx >= 10), 64'd1);
    #2 exp_active = 1'b0;
    rstn = 1'b0;
    #1 check_reset("reset_mid_drain");
    ready_mode = 0;
    @(negedge clk) rstn = 1'b1;
    tick();
    check("idle_after_drain_reset", 64'({smp_busy, smp_m_valid, smp_s_ready}), 64'(3'b001));

    // Clean frame after the aborted ones
    fill_random();
    run_frame("post_reset", 24, 1'b1, 2, 0);
    check("post_reset_bits", 64'(got_grid), 64'(exp_grid));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
